// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 key source.
//   ps2_rx_state_t : frame receiver states
//   PS2_EXT/REL/PAUSE : prefix bytes recognised by the decoder
//   PS2_DROP / is_dropped() : keyboard housekeeping bytes that never form a key event
//   KEY_STROBE/KEY_PRESSED/KEY_EXT : bit positions inside the 11-bit ps2_key word
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_rx_state_t;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_REL   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // BAT ok, ACK, resend, echo, buffer overrun/error codes
  localparam int         PS2_NUM_DROP = 6;
  localparam logic [7:0] PS2_DROP [PS2_NUM_DROP] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

  localparam int KEY_STROBE  = 10;
  localparam int KEY_PRESSED = 9;
  localparam int KEY_EXT     = 8;

  function automatic logic is_dropped(input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < PS2_NUM_DROP; i++) begin
      if (code == PS2_DROP[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises the raw PS/2 pins, debounces the clock line and
// deserialises 11-bit frames (start, 8 data LSB first, odd parity, stop).
//   clk, reset        : system clock, synchronous active-high reset
//   ps2_clk, ps2_data : raw asynchronous pins
//   byte_valid        : one-cycle pulse, rx_byte holds a good byte
//   rx_byte[7:0]      : last received byte
//   err               : one-cycle pulse on parity/stop failure or mid-frame timeout
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       err
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // Two-flop synchronisers; index 1 = clock pin, 0 = data pin. Idle bus is high.
  logic [1:0] pins;
  assign pins = {ps2_clk, ps2_data};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    logic meta_reg;
    logic sync_reg;
    always_ff @(posedge clk) begin
      if (reset) begin
        meta_reg <= 1'b1;
        sync_reg <= 1'b1;
      end else begin
        meta_reg <= pins[gi];
        sync_reg <= meta_reg;
      end
    end
  end

  logic clk_s;
  logic dat_s;
  assign clk_s = g_sync[1].sync_reg;
  assign dat_s = g_sync[0].sync_reg;

  // Glitch filter: the filtered level follows only after FILTER_LEN
  // consecutive synchronised samples disagree with it.
  logic          filt_reg;
  logic          filt_prev_reg;
  logic [CW-1:0] filt_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_reg      <= 1'b1;
      filt_prev_reg <= 1'b1;
      filt_cnt_reg  <= '0;
    end else begin
      filt_prev_reg <= filt_reg;
      if (clk_s == filt_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == CW'(FILTER_LEN - 1)) begin
        filt_reg     <= clk_s;
        filt_cnt_reg <= '0;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
    end
  end

  logic fall;
  assign fall = filt_prev_reg & ~filt_reg;

  // Frame FSM
  ps2_rx_state_t state_reg, state_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic          parity_ok_reg, parity_ok_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic          valid_reg, valid_next;
  logic          err_reg, err_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      parity_ok_reg <= 1'b0;
      tmo_reg       <= '0;
      valid_reg     <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      parity_ok_reg <= parity_ok_next;
      tmo_reg       <= tmo_next;
      valid_reg     <= valid_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    parity_ok_next = parity_ok_reg;
    valid_next     = 1'b0;
    err_next       = 1'b0;

    if (state_reg == IDLE || fall) tmo_next = '0;
    else                           tmo_next = tmo_reg + 1'b1;

    case (state_reg)
      IDLE: begin
        // A falling edge with data high is line noise, not a start bit.
        if (fall && !dat_s) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_next   = {dat_s, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == 3'd7) state_next = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          // Odd parity: data bits plus parity bit hold an odd count of ones.
          parity_ok_next = ^{shift_reg, dat_s};
          state_next     = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_next = IDLE;
          if (dat_s && parity_ok_reg) valid_next = 1'b1;
          else                        err_next   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (state_reg != IDLE && !fall && tmo_reg == TW'(TIMEOUT_CYCLES - 1)) begin
      state_next = IDLE;
      err_next   = 1'b1;
    end
  end

  assign byte_valid = valid_reg;
  assign rx_byte    = shift_reg;
  assign err        = err_reg;

endmodule

// File: rtl/ps2_key_source.sv
// ps2_key_source: turns a raw PS/2 keyboard stream into the 11-bit ps2_key
// event word {strobe, pressed, extended, scancode}.
//   clk, reset        : system clock, synchronous active-high reset
//   ps2_clk, ps2_data : raw asynchronous PS/2 pins
//   ps2_key[10:0]     : event word; bit 10 toggles once per key event
//   frame_error       : one-cycle pulse on a bad or timed-out frame
module ps2_key_source
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_error
);

  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       rx_err;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .err       (rx_err)
  );

  logic [10:0] key_reg;
  logic        ext_reg;
  logic        rel_reg;
  logic [2:0]  skip_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_reg  <= '0;
      ext_reg  <= 1'b0;
      rel_reg  <= 1'b0;
      skip_reg <= '0;
    end else if (rx_err) begin
      ext_reg <= 1'b0;
      rel_reg <= 1'b0;
    end else if (byte_valid) begin
      if (skip_reg != '0) begin
        // Inside the Pause sequence: swallow bytes, leave flags alone.
        skip_reg <= skip_reg - 1'b1;
      end else if (rx_byte == PS2_PAUSE) begin
        skip_reg <= 3'd7;
      end else if (rx_byte == PS2_EXT) begin
        ext_reg <= 1'b1;
      end else if (rx_byte == PS2_REL) begin
        rel_reg <= 1'b1;
      end else if (is_dropped(rx_byte)) begin
        ext_reg <= 1'b0;
        rel_reg <= 1'b0;
      end else begin
        key_reg[KEY_STROBE]  <= ~key_reg[KEY_STROBE];
        key_reg[KEY_PRESSED] <= ~rel_reg;
        key_reg[KEY_EXT]     <= ext_reg;
        key_reg[7:0]         <= rx_byte;
        ext_reg              <= 1'b0;
        rel_reg              <= 1'b0;
      end
    end
  end

  assign ps2_key     = key_reg;
  assign frame_error = rx_err;

endmodule
